// File: rtl/lfsr_random_stream_if.sv
// Valid/ready stream carrying random words from the LFSR source to a consumer.
interface lfsr_random_stream_if #(
  parameter int unsigned WIDTH = 12
);
  logic [WIDTH-1:0] rnd_data;
  logic             rnd_valid;
  logic             rnd_ready;

  modport master (output rnd_data, output rnd_valid, input rnd_ready);
  modport slave  (input rnd_data, input rnd_valid, output rnd_ready);
endinterface

// File: rtl/lfsr_random_stream.sv
// Fibonacci LFSR random-word source with valid/ready output, runtime seed load,
// periodic self-reseed after a number of accepted words and all-zero lock-up recovery.
module lfsr_random_stream #(
  parameter int unsigned WIDTH           = 12,
  parameter logic [31:0] TAPS            = 32'h0000_0C09,
  parameter int unsigned RESET_SEED      = 1,
  parameter int unsigned RESEED_INTERVAL = 1000,
  parameter int unsigned CNT_W           = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    seed_load,
  input  logic [WIDTH-1:0]        seed_in,
  input  logic                    reseed_en,
  lfsr_random_stream_if.master    out_if,
  output logic                    lockup
);

  localparam logic [WIDTH-1:0] TAP_MASK  = TAPS[WIDTH-1:0];
  localparam logic [WIDTH-1:0] SEED_RST  = WIDTH'(RESET_SEED);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(RESEED_INTERVAL - 1);

  // Elaboration-time parameter legality.
  if (WIDTH < 3 || WIDTH > 32) begin : g_bad_width
    $error("lfsr_random_stream: WIDTH must be in 3..32");
  end
  if (TAPS[WIDTH-1] != 1'b1) begin : g_bad_taps
    $error("lfsr_random_stream: TAPS[WIDTH-1] must be set");
  end
  if (RESET_SEED == 0) begin : g_bad_seed
    $error("lfsr_random_stream: RESET_SEED must be nonzero");
  end
  if (RESEED_INTERVAL == 0 ||
      64'(RESEED_INTERVAL) >= (64'(1) << CNT_W)) begin : g_bad_interval
    $error("lfsr_random_stream: RESEED_INTERVAL must be in 1..2**CNT_W-1");
  end

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_RESEED = 2'd2
  } fsm_e;

  fsm_e             fsm_q,    fsm_d;
  logic [WIDTH-1:0] state_q,  state_d;
  logic [WIDTH-1:0] seed_q,   seed_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic             lockup_q, lockup_d;

  logic             valid_c;
  logic             xfer_c;
  logic             terminal_c;
  logic             zero_det_c;
  logic [WIDTH-1:0] next_c;
  logic [WIDTH-1:0] mix_c;
  logic [WIDTH-1:0] load_val_c;

  // Shared combinational terms.
  assign valid_c    = (fsm_q == ST_RUN) && (state_q != '0);
  assign xfer_c     = valid_c && out_if.rnd_ready;
  assign terminal_c = (cnt_q == CNT_LAST);
  assign zero_det_c = (state_q == '0) && (fsm_q != ST_RESEED);
  assign next_c     = {state_q[WIDTH-2:0], ^(state_q & TAP_MASK)};
  assign mix_c      = state_q ^ seed_q;
  assign load_val_c = (seed_in == '0) ? SEED_RST : seed_in;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q    <= ST_IDLE;
      state_q  <= SEED_RST;
      seed_q   <= SEED_RST;
      cnt_q    <= '0;
      lockup_q <= 1'b0;
    end else begin
      fsm_q    <= fsm_d;
      state_q  <= state_d;
      seed_q   <= seed_d;
      cnt_q    <= cnt_d;
      lockup_q <= lockup_d;
    end
  end

  // Next-state logic; seed load wins, lock-up recovery freezes the FSM.
  always_comb begin
    fsm_d = fsm_q;
    if (seed_load) begin
      fsm_d = ST_IDLE;
    end else if (!zero_det_c) begin
      unique case (fsm_q)
        ST_IDLE: begin
          if (en) fsm_d = ST_RUN;
        end
        ST_RUN: begin
          if (xfer_c && terminal_c && reseed_en) fsm_d = ST_RESEED;
          else if (!en)                          fsm_d = ST_IDLE;
        end
        ST_RESEED: begin
          fsm_d = en ? ST_RUN : ST_IDLE;
        end
        default: fsm_d = ST_IDLE;
      endcase
    end
  end

  // Datapath updates and outputs.
  always_comb begin
    state_d  = state_q;
    seed_d   = seed_q;
    cnt_d    = cnt_q;
    lockup_d = 1'b0;
    if (seed_load) begin
      state_d = load_val_c;
      seed_d  = load_val_c;
      cnt_d   = '0;
    end else if (zero_det_c) begin
      state_d  = SEED_RST;
      lockup_d = 1'b1;
    end else if (fsm_q == ST_RESEED) begin
      // Fold the previous seed into the state; old state becomes the new seed.
      state_d = (mix_c == '0) ? SEED_RST : mix_c;
      seed_d  = state_q;
    end else if (xfer_c) begin
      state_d = next_c;
      cnt_d   = terminal_c ? '0 : cnt_q + CNT_W'(1);
    end
  end

  assign out_if.rnd_data  = state_q;
  assign out_if.rnd_valid = valid_c;
  assign lockup           = lockup_q;

endmodule

// File: tb/tb_lfsr_random_stream.sv
// Bench for lfsr_random_stream: directed vector table, lock-up/reset sequences
// and randomized traffic against a behavioural reference model.
module tb_lfsr_random_stream;

  localparam int unsigned W        = 12;
  localparam logic [W-1:0] TAPS    = 12'hC09;
  localparam int unsigned INTERVAL = 4;

  logic         clk;
  logic         rst_n;
  logic         en;
  logic         seed_load;
  logic [W-1:0] seed_in;
  logic         reseed_en;
  logic         lockup;

  int n_checks;
  int n_fail;

  lfsr_random_stream_if #(.WIDTH(W)) rnd_if ();

  lfsr_random_stream #(
    .WIDTH          (W),
    .TAPS           (32'h0000_0C09),
    .RESET_SEED     (1),
    .RESEED_INTERVAL(INTERVAL),
    .CNT_W          (16)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .seed_load(seed_load),
    .seed_in  (seed_in),
    .reseed_en(reseed_en),
    .out_if   (rnd_if),
    .lockup   (lockup)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: abstract stream state, not the DUT's encoding.
  logic [W-1:0] m_state;
  logic [W-1:0] m_seed;
  int           m_xfers;
  bit           m_run;
  bit           m_reseed;
  bit           m_lock;

  function automatic logic [W-1:0] lfsr_next(input logic [W-1:0] s);
    int ones;
    ones = $countones(s & TAPS);
    return W'((int'(s) * 2 + (ones % 2)) % (1 << W));
  endfunction

  task automatic model_reset();
    m_state  = 12'h001;
    m_seed   = 12'h001;
    m_xfers  = 0;
    m_run    = 1'b0;
    m_reseed = 1'b0;
    m_lock   = 1'b0;
  endtask

  task automatic model_step();
    bit           offered;
    logic [W-1:0] t;
    offered = m_run && (m_state != '0);
    if (seed_load) begin
      m_state  = (seed_in == '0) ? 12'h001 : seed_in;
      m_seed   = m_state;
      m_xfers  = 0;
      m_run    = 1'b0;
      m_reseed = 1'b0;
      m_lock   = 1'b0;
    end else if (!m_reseed && m_state == '0) begin
      m_state = 12'h001;
      m_lock  = 1'b1;
    end else begin
      m_lock = 1'b0;
      if (m_reseed) begin
        t        = m_state ^ m_seed;
        m_seed   = m_state;
        m_state  = (t == '0) ? 12'h001 : t;
        m_reseed = 1'b0;
        m_run    = en;
      end else if (!m_run) begin
        m_run = en;
      end else begin
        if (offered && rnd_if.rnd_ready) begin
          m_state = lfsr_next(m_state);
          m_xfers++;
          if (m_xfers == INTERVAL) begin
            m_xfers = 0;
            if (reseed_en) begin
              m_reseed = 1'b1;
              m_run    = 1'b0;
            end
          end
        end
        if (!m_reseed && !en) m_run = 1'b0;
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_compare(input string tag);
    check({tag, "_data"},   32'(rnd_if.rnd_data),  32'(m_state));
    check({tag, "_valid"},  32'(rnd_if.rnd_valid), 32'(m_run && (m_state != '0)));
    check({tag, "_lockup"}, 32'(lockup),           32'(m_lock));
  endtask

  // Called just after a falling edge with inputs already applied.
  task automatic tick(input string tag);
    #1;
    model_compare(tag);
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  typedef struct {
    bit           en;
    bit           rdy;
    bit           ld;
    logic [W-1:0] sin;
    bit           rs;
    bit           v;
    logic [W-1:0] d;
  } vec_t;

  function automatic vec_t mk(bit e, bit r, bit l, logic [W-1:0] s, bit rs, bit v, logic [W-1:0] d);
    vec_t x;
    x.en = e; x.rdy = r; x.ld = l; x.sin = s; x.rs = rs; x.v = v; x.d = d;
    return x;
  endfunction

  vec_t vecs[22];

  initial begin
    n_checks = 0;
    n_fail   = 0;

    // en, ready, seed_load, seed_in, reseed_en -> expected valid, data this cycle
    vecs[0]  = mk(1, 1, 0, 12'h000, 0, 0, 12'h001);
    vecs[1]  = mk(1, 1, 0, 12'h000, 0, 1, 12'h001);
    vecs[2]  = mk(1, 1, 0, 12'h000, 0, 1, 12'h003);
    vecs[3]  = mk(1, 0, 0, 12'h000, 0, 1, 12'h007);
    vecs[4]  = mk(1, 0, 0, 12'h000, 0, 1, 12'h007);
    vecs[5]  = mk(1, 0, 0, 12'h000, 0, 1, 12'h007);
    vecs[6]  = mk(1, 0, 0, 12'h000, 0, 1, 12'h007);
    vecs[7]  = mk(1, 0, 0, 12'h000, 0, 1, 12'h007);
    vecs[8]  = mk(1, 1, 0, 12'h000, 0, 1, 12'h007);
    vecs[9]  = mk(1, 1, 0, 12'h000, 1, 1, 12'h00F);
    vecs[10] = mk(1, 1, 0, 12'h000, 1, 0, 12'h01E);
    vecs[11] = mk(1, 1, 0, 12'h000, 1, 1, 12'h01F);
    vecs[12] = mk(1, 1, 0, 12'h000, 1, 1, 12'h03E);
    vecs[13] = mk(1, 1, 0, 12'h000, 0, 1, 12'h07D);
    vecs[14] = mk(1, 1, 0, 12'h000, 0, 1, 12'h0FA);
    vecs[15] = mk(1, 1, 1, 12'hABC, 0, 1, 12'h1F5);
    vecs[16] = mk(1, 1, 0, 12'h000, 0, 0, 12'hABC);
    vecs[17] = mk(1, 1, 0, 12'h000, 0, 1, 12'hABC);
    vecs[18] = mk(1, 1, 1, 12'h000, 0, 1, 12'h578);
    vecs[19] = mk(1, 1, 0, 12'h000, 0, 0, 12'h001);
    vecs[20] = mk(0, 1, 0, 12'h000, 0, 1, 12'h001);
    vecs[21] = mk(0, 1, 0, 12'h000, 0, 0, 12'h003);

    rst_n            = 1'b0;
    en               = 1'b0;
    seed_load        = 1'b0;
    seed_in          = '0;
    reseed_en        = 1'b0;
    rnd_if.rnd_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check("reset_data",   32'(rnd_if.rnd_data),  32'h001);
    check("reset_valid",  32'(rnd_if.rnd_valid), 32'h0);
    check("reset_lockup", 32'(lockup),           32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table: startup sequence, backpressure, reseed, seed loads, en drop.
    for (int i = 0; i < 22; i++) begin
      en               = vecs[i].en;
      rnd_if.rnd_ready = vecs[i].rdy;
      seed_load        = vecs[i].ld;
      seed_in          = vecs[i].sin;
      reseed_en        = vecs[i].rs;
      #1;
      check($sformatf("vec%0d_valid", i), 32'(rnd_if.rnd_valid), 32'(vecs[i].v));
      check($sformatf("vec%0d_data", i),  32'(rnd_if.rnd_data),  32'(vecs[i].d));
      tick($sformatf("vec%0d_model", i));
    end
    seed_load = 1'b0;

    // Lock-up: zero the state while running.
    en               = 1'b1;
    rnd_if.rnd_ready = 1'b1;
    tick("lk_pre0");
    tick("lk_pre1");
    force dut.state_q = '0;
    #1;
    check("lk_valid_zero", 32'(rnd_if.rnd_valid), 32'h0);
    release dut.state_q;
    m_state = '0;
    tick("lk_zero");
    #1;
    check("lk_pulse", 32'(lockup),           32'h1);
    check("lk_data",  32'(rnd_if.rnd_data),  32'h001);
    check("lk_valid", 32'(rnd_if.rnd_valid), 32'h1);
    tick("lk_after0");
    #1;
    check("lk_pulse_end", 32'(lockup), 32'h0);
    tick("lk_after1");

    // Asynchronous reset between edges while running.
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_valid", 32'(rnd_if.rnd_valid), 32'h0);
    check("rst_mid_data",  32'(rnd_if.rnd_data),  32'h001);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_rel_valid", 32'(rnd_if.rnd_valid), 32'h0);
    tick("rst_rel0");
    #1;
    check("rst_rel_first", 32'(rnd_if.rnd_data),  32'h001);
    check("rst_rel_v1",    32'(rnd_if.rnd_valid), 32'h1);
    tick("rst_rel1");
    #1;
    check("rst_rel_second", 32'(rnd_if.rnd_data), 32'h003);
    tick("rst_rel2");

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      en               = ($urandom % 8) != 0;
      rnd_if.rnd_ready = ($urandom % 4) != 0;
      seed_load        = ($urandom % 60) == 0;
      seed_in          = (($urandom % 4) == 0) ? '0 : W'($urandom);
      reseed_en        = ($urandom % 3) != 0;
      tick("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
